// File: rtl/mcse_bus_arbiter.sv
// mcse_bus_arbiter
// Two-requester (boot, fw) arbiter in front of a single downstream bus port.
// Each requester owns a one-deep request buffer. The FSM grants one buffered
// request at a time, issues it downstream, waits for completion or timeout,
// and returns the result to the requester that issued it.
// Ties alternate between the requesters, starting with boot after reset.

module mcse_bus_arbiter #(
    parameter int pAHB_ADDR_WIDTH    = 32,
    parameter int pPAYLOAD_SIZE_BITS = 256,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                          clk,
    input  logic                          rst,

    // boot requester
    input  logic                          boot_go,
    input  logic [pAHB_ADDR_WIDTH-1:0]    boot_addr,
    input  logic [pPAYLOAD_SIZE_BITS-1:0] boot_wdata,
    input  logic                          boot_rw,
    output logic                          boot_done,
    output logic [pPAYLOAD_SIZE_BITS-1:0] boot_rdata,
    output logic                          boot_err,
    output logic                          boot_drop,

    // fw requester
    input  logic                          fw_go,
    input  logic [pAHB_ADDR_WIDTH-1:0]    fw_addr,
    input  logic [pPAYLOAD_SIZE_BITS-1:0] fw_wdata,
    input  logic                          fw_rw,
    output logic                          fw_done,
    output logic [pPAYLOAD_SIZE_BITS-1:0] fw_rdata,
    output logic                          fw_err,
    output logic                          fw_drop,

    // downstream port
    output logic                          bus_go,
    output logic [pAHB_ADDR_WIDTH-1:0]    bus_addr,
    output logic [pPAYLOAD_SIZE_BITS-1:0] bus_write,
    output logic                          bus_RW,
    input  logic                          bus_done,
    input  logic [pPAYLOAD_SIZE_BITS-1:0] bus_rdData,

    // status
    output logic                          busy,
    output logic                          grant_id
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Per-requester request buffers
    logic                          pending_boot;
    logic [pAHB_ADDR_WIDTH-1:0]    boot_addr_q;
    logic [pPAYLOAD_SIZE_BITS-1:0] boot_wdata_q;
    logic                          boot_rw_q;

    logic                          pending_fw;
    logic [pAHB_ADDR_WIDTH-1:0]    fw_addr_q;
    logic [pPAYLOAD_SIZE_BITS-1:0] fw_wdata_q;
    logic                          fw_rw_q;

    // Arbitration and transaction tracking
    logic             last_grant;
    logic             grant_nxt;
    logic             grant_fire;
    logic             wait_end;
    logic             timeout_hit;
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    logic resp_boot;
    logic resp_fw;
    logic boot_accept;
    logic fw_accept;

    // grant_id always names the owner of the transaction in flight, so RESP
    // can route the completion with it directly.
    assign resp_boot = (state == S_RESP) && (grant_id == 1'b0);
    assign resp_fw   = (state == S_RESP) && (grant_id == 1'b1);

    // A request is taken when the buffer is free, or when the buffer is
    // being released in this very cycle by its own RESP (set wins over clear).
    assign boot_accept = boot_go && (!pending_boot || resp_boot);
    assign fw_accept   = fw_go   && (!pending_fw   || resp_fw);

    assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_MAX);
    assign grant_fire  = (state == S_IDLE) && (state_nxt == S_ISSUE);
    assign wait_end    = (state == S_WAIT) && (state_nxt == S_RESP);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and arbitration decision
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing
        // branch would otherwise infer a latch.
        state_nxt = state;
        grant_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending_boot && pending_fw) begin
                    grant_nxt = ~last_grant;
                    state_nxt = S_ISSUE;
                end else if (pending_boot) begin
                    grant_nxt = 1'b0;
                    state_nxt = S_ISSUE;
                end else if (pending_fw) begin
                    grant_nxt = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus_done || timeout_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Completion and status outputs decoded from the current state
    always_comb begin
        busy      = (state != S_IDLE);
        boot_done = resp_boot;
        fw_done   = resp_fw;
        boot_err  = resp_boot && err_q;
        fw_err    = resp_fw && err_q;
    end

    // Request capture: pending flags and drop pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_boot <= 1'b0;
            pending_fw   <= 1'b0;
            boot_drop    <= 1'b0;
            fw_drop      <= 1'b0;
        end else begin
            if (boot_accept) begin
                pending_boot <= 1'b1;
            end else if (resp_boot) begin
                pending_boot <= 1'b0;
            end

            if (fw_accept) begin
                pending_fw <= 1'b1;
            end else if (resp_fw) begin
                pending_fw <= 1'b0;
            end

            boot_drop <= boot_go && !boot_accept;
            fw_drop   <= fw_go && !fw_accept;
        end
    end

    // Request payload buffers
    always_ff @(posedge clk) begin
        // NOTE: payload buffers carry no reset; they are only read after
        // their pending flag (which is reset) has been set by a capture.
        if (boot_accept) begin
            boot_addr_q  <= boot_addr;
            boot_wdata_q <= boot_wdata;
            boot_rw_q    <= boot_rw;
        end
        if (fw_accept) begin
            fw_addr_q  <= fw_addr;
            fw_wdata_q <= fw_wdata;
            fw_rw_q    <= fw_rw;
        end
    end

    // Transaction datapath: grant, issue pulse, wait counter, response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            bus_go     <= 1'b0;
            bus_addr   <= '0;
            bus_write  <= '0;
            bus_RW     <= 1'b0;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
            boot_rdata <= '0;
            fw_rdata   <= '0;
        end else begin
            bus_go <= (state == S_ISSUE);

            if (grant_fire) begin
                last_grant <= grant_nxt;
                grant_id   <= grant_nxt;
                bus_addr   <= grant_nxt ? fw_addr_q  : boot_addr_q;
                bus_write  <= grant_nxt ? fw_wdata_q : boot_wdata_q;
                bus_RW     <= grant_nxt ? fw_rw_q    : boot_rw_q;
            end

            if ((state == S_WAIT) && (state_nxt == S_WAIT)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            // bus_done takes priority over an expiry in the same cycle
            if (wait_end) begin
                err_q <= !bus_done;
                if (grant_id == 1'b0) begin
                    boot_rdata <= bus_done ? bus_rdData : '0;
                end else begin
                    fw_rdata <= bus_done ? bus_rdData : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcse_bus_arbiter.sv
// tb_mcse_bus_arbiter
// Directed bench for mcse_bus_arbiter with TIMEOUT_CYCLES=8. Cycle k is the
// interval after clock edge k; inputs are driven and outputs sampled 1 time
// unit after each rising edge.

module tb_mcse_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          boot_go, fw_go;
    logic [AW-1:0] boot_addr, fw_addr;
    logic [DW-1:0] boot_wdata, fw_wdata;
    logic          boot_rw, fw_rw;
    logic          boot_done, fw_done;
    logic [DW-1:0] boot_rdata, fw_rdata;
    logic          boot_err, fw_err;
    logic          boot_drop, fw_drop;
    logic          bus_go;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_write;
    logic          bus_RW;
    logic          bus_done;
    logic [DW-1:0] bus_rdData;
    logic          busy;
    logic          grant_id;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [DW-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [DW-1:0] PAT_5A = {32{8'h5A}};
    localparam logic [DW-1:0] PAT_C3 = {32{8'hC3}};
    localparam logic [DW-1:0] PAT_3C = {32{8'h3C}};
    localparam logic [DW-1:0] PAT_F0 = {32{8'hF0}};
    localparam logic [DW-1:0] PAT_WR = {8{32'hDEAD_BEEF}};

    mcse_bus_arbiter #(
        .pAHB_ADDR_WIDTH   (AW),
        .pPAYLOAD_SIZE_BITS(DW),
        .TIMEOUT_CYCLES    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .boot_go   (boot_go),
        .boot_addr (boot_addr),
        .boot_wdata(boot_wdata),
        .boot_rw   (boot_rw),
        .boot_done (boot_done),
        .boot_rdata(boot_rdata),
        .boot_err  (boot_err),
        .boot_drop (boot_drop),
        .fw_go     (fw_go),
        .fw_addr   (fw_addr),
        .fw_wdata  (fw_wdata),
        .fw_rw     (fw_rw),
        .fw_done   (fw_done),
        .fw_rdata  (fw_rdata),
        .fw_err    (fw_err),
        .fw_drop   (fw_drop),
        .bus_go    (bus_go),
        .bus_addr  (bus_addr),
        .bus_write (bus_write),
        .bus_RW    (bus_RW),
        .bus_done  (bus_done),
        .bus_rdData(bus_rdData),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] observed,
                         input logic [DW-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Step until bus_go is seen, bounded by a cycle budget
    task automatic wait_bus_go(input string tag);
        int n = 0;
        while (bus_go !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        check(tag, bus_go, 1'b1);
    endtask

    // Serve one granted transaction: expect the grant, answer one cycle after
    // bus_go, check the response, optionally re-request in the RESP cycle.
    task automatic serve(input string tag, input bit exp_fw,
                         input logic [AW-1:0] exp_addr, input logic [DW-1:0] rd,
                         input bit reissue, input logic [AW-1:0] new_addr);
        wait_bus_go({tag, "_go"});
        check({tag, "_grant"}, grant_id, exp_fw);
        check({tag, "_addr"}, bus_addr, exp_addr);
        step();
        bus_done   = 1'b1;
        bus_rdData = rd;
        step();
        bus_done = 1'b0;
        check({tag, "_done"}, exp_fw ? fw_done : boot_done, 1'b1);
        check({tag, "_rdata"}, exp_fw ? fw_rdata : boot_rdata, rd);
        if (reissue) begin
            if (exp_fw) begin
                fw_go   = 1'b1;
                fw_addr = new_addr;
            end else begin
                boot_go   = 1'b1;
                boot_addr = new_addr;
            end
        end
        step();
        boot_go = 1'b0;
        fw_go   = 1'b0;
        if (reissue) begin
            check({tag, "_nodrop"}, exp_fw ? fw_drop : boot_drop, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        boot_go    = 1'b0;
        fw_go      = 1'b0;
        boot_addr  = '0;
        fw_addr    = '0;
        boot_wdata = '0;
        fw_wdata   = '0;
        boot_rw    = 1'b0;
        fw_rw      = 1'b0;
        bus_done   = 1'b0;
        bus_rdData = '0;

        // ---- reset state ----
        repeat (2) step();
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant_id, 1'b0);
        check("rst_bus_go", bus_go, 1'b0);
        check("rst_bus_addr", bus_addr, '0);
        check("rst_boot_done", boot_done, 1'b0);

        // ---- single read: go at edge 0, bus_go cycle 2, bus_done cycle 5 ----
        rst       = 1'b0;
        boot_go   = 1'b1;
        boot_addr = 32'h1000;
        boot_rw   = 1'b0;
        step();                                  // cycle 0
        boot_go = 1'b0;
        check("rd_c0_busy", busy, 1'b0);
        step();                                  // cycle 1
        check("rd_c1_busy", busy, 1'b1);
        check("rd_c1_bus_go", bus_go, 1'b0);
        step();                                  // cycle 2
        check("rd_c2_bus_go", bus_go, 1'b1);
        check("rd_c2_addr", bus_addr, 32'h1000);
        check("rd_c2_rw", bus_RW, 1'b0);
        step();                                  // cycle 3
        check("rd_c3_bus_go", bus_go, 1'b0);
        step();                                  // cycle 4
        step();                                  // cycle 5
        bus_done   = 1'b1;
        bus_rdData = PAT_A5;
        check("rd_c5_done", boot_done, 1'b0);
        step();                                  // cycle 6
        bus_done = 1'b0;
        check("rd_c6_done", boot_done, 1'b1);
        check("rd_c6_rdata", boot_rdata, PAT_A5);
        check("rd_c6_err", boot_err, 1'b0);
        check("rd_c6_fw_done", fw_done, 1'b0);
        step();                                  // cycle 7
        check("rd_c7_done", boot_done, 1'b0);
        check("rd_c7_busy", busy, 1'b0);
        check("rd_c7_hold", boot_rdata, PAT_A5);

        // ---- contention: ties alternate boot, fw, boot, then fw alone ----
        rst = 1'b1;
        step();
        rst       = 1'b0;
        boot_go   = 1'b1;
        fw_go     = 1'b1;
        boot_addr = 32'h2000;
        fw_addr   = 32'h3000;
        step();
        boot_go = 1'b0;
        fw_go   = 1'b0;
        serve("tie1_boot", 1'b0, 32'h2000, PAT_5A, 1'b1, 32'h2100);
        serve("tie2_fw", 1'b1, 32'h3000, PAT_C3, 1'b1, 32'h3100);
        serve("tie3_boot", 1'b0, 32'h2100, PAT_3C, 1'b0, '0);
        serve("tie4_fw", 1'b1, 32'h3100, PAT_F0, 1'b0, '0);
        check("tie_idle", busy, 1'b0);

        // ---- duplicate request while boot is pending ----
        boot_go   = 1'b1;
        boot_addr = 32'h4000;
        step();                                  // cycle 0: pending set
        boot_addr = 32'h4444;                    // boot_go still high
        step();                                  // cycle 1
        boot_go = 1'b0;
        check("dup_drop", boot_drop, 1'b1);
        check("dup_c1_addr", bus_addr, 32'h4000);
        step();                                  // cycle 2
        check("dup_c2_go", bus_go, 1'b1);
        check("dup_c2_addr", bus_addr, 32'h4000);
        check("dup_c2_drop", boot_drop, 1'b0);
        step();
        bus_done   = 1'b1;
        bus_rdData = PAT_5A;
        step();                                  // RESP
        bus_done = 1'b0;
        check("dup_done", boot_done, 1'b1);
        repeat (3) step();
        check("dup_no_regrant", busy, 1'b0);

        // ---- timeout: fw write, no bus_done; RESP 8 cycles after WAIT entry ----
        fw_go    = 1'b1;
        fw_addr  = 32'h5000;
        fw_wdata = PAT_WR;
        fw_rw    = 1'b1;
        step();                                  // cycle 0
        fw_go = 1'b0;
        step();                                  // cycle 1
        step();                                  // cycle 2: WAIT entry
        check("to_go", bus_go, 1'b1);
        check("to_rw", bus_RW, 1'b1);
        check("to_wdata", bus_write, PAT_WR);
        repeat (7) step();                       // cycle 9
        check("to_c9_done", fw_done, 1'b0);
        step();                                  // cycle 10
        check("to_done", fw_done, 1'b1);
        check("to_err", fw_err, 1'b1);
        check("to_rdata", fw_rdata, '0);
        bus_done   = 1'b1;                       // late completion
        bus_rdData = PAT_A5;
        step();
        bus_done = 1'b0;
        check("to_late_done", fw_done, 1'b0);
        check("to_late_err", fw_err, 1'b0);
        check("to_late_busy", busy, 1'b0);
        step();
        check("to_late_rdata", fw_rdata, '0);

        // ---- reset during WAIT ----
        boot_go   = 1'b1;
        boot_addr = 32'h6000;
        boot_rw   = 1'b0;
        step();                                  // cycle 0
        boot_go = 1'b0;
        step();                                  // cycle 1
        step();                                  // cycle 2
        step();                                  // cycle 3: WAIT
        check("rw_in_wait", busy, 1'b1);
        rst = 1'b1;
        step();                                  // cycle 4
        rst = 1'b0;
        check("rw_busy", busy, 1'b0);
        check("rw_addr", bus_addr, '0);
        check("rw_boot_rdata", boot_rdata, '0);
        check("rw_fw_rdata", fw_rdata, '0);
        check("rw_boot_done", boot_done, 1'b0);
        bus_done   = 1'b1;
        bus_rdData = PAT_C3;
        step();
        bus_done = 1'b0;
        check("rw_late_done", boot_done, 1'b0);
        repeat (3) step();
        check("rw_late_busy", busy, 1'b0);
        check("rw_late_rdata", boot_rdata, '0);

        // ---- back-to-back: boot_go in boot's RESP -> bus_go 2 cycles later ----
        boot_go   = 1'b1;
        boot_addr = 32'h7000;
        step();
        boot_go = 1'b0;
        step();
        step();                                  // first bus_go
        check("b2b_go1", bus_go, 1'b1);
        step();
        bus_done   = 1'b1;
        bus_rdData = PAT_3C;
        step();                                  // RESP
        bus_done = 1'b0;
        check("b2b_done1", boot_done, 1'b1);
        boot_go   = 1'b1;
        boot_addr = 32'h7100;
        step();                                  // go sampled at edge t
        boot_go = 1'b0;
        check("b2b_nodrop", boot_drop, 1'b0);
        check("b2b_t0_go", bus_go, 1'b0);
        step();                                  // t+1
        check("b2b_t1_go", bus_go, 1'b0);
        step();                                  // t+2
        check("b2b_go2", bus_go, 1'b1);
        check("b2b_addr2", bus_addr, 32'h7100);
        step();
        bus_done   = 1'b1;
        bus_rdData = PAT_F0;
        step();
        bus_done = 1'b0;
        check("b2b_done2", boot_done, 1'b1);
        check("b2b_rdata2", boot_rdata, PAT_F0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mcse_bus_arbiter.md
MCSE_BUS_ARBITER -- requirements
Module: mcse_bus_arbiter

Interface
REQ-001 SHALL have parameter pAHB_ADDR_WIDTH, default 32, meaning address width of every request and of the downstream port.
REQ-002 SHALL have parameter pPAYLOAD_SIZE_BITS, default 256, meaning write and read payload width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of WAIT cycles before a transaction is aborted.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports in this order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
REQ-005 SHALL have, per requester X in {boot, fw}:
- X_go  in  1  single-cycle request pulse.
- X_addr  in  pAHB_ADDR_WIDTH  request address.
- X_wdata  in  pPAYLOAD_SIZE_BITS  write payload.
- X_rw  in  1  direction: 1 = write, 0 = read.
- X_done  out  1  single-cycle completion pulse.
- X_rdata  out  pPAYLOAD_SIZE_BITS  read payload.
- X_err  out  1  timeout flag, valid with X_done.
- X_drop  out  1  single-cycle pulse: a request was ignored.
REQ-006 SHALL have the downstream port:
- bus_go  out  1  issue pulse.
- bus_addr  out  pAHB_ADDR_WIDTH  address.
- bus_write  out  pPAYLOAD_SIZE_BITS  write payload.
- bus_RW  out  1  direction.
- bus_done  in  1  completion pulse.
- bus_rdData  in  pPAYLOAD_SIZE_BITS  read data.
REQ-007 SHALL have status outputs:
- busy  out  1  FSM is not in IDLE.
- grant_id  out  1  current or last grant: 0 = boot, 1 = fw.

Function
REQ-008 On X_go, SHALL latch X_addr, X_wdata and X_rw into a per-requester buffer and set pending_X.
REQ-009 When X_go arrives while pending_X=1, SHALL ignore it: the buffer is unchanged and X_drop pulses in the next cycle.
- Exception: X_go in the RESP cycle of requester X's own transaction is accepted; set wins over clear.
REQ-010 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; the reset state is IDLE.
REQ-011 IDLE transitions:
- No pending request: stay in IDLE.
- One requester pending: grant it and go to ISSUE.
- Both pending: grant the requester not equal to last_grant and go to ISSUE.
- last_grant resets to 1, so boot wins the first tie.
REQ-012 On grant, SHALL update last_grant and grant_id, and drive bus_addr, bus_write and bus_RW from the granted buffer.
- These outputs hold their value until the next grant.
REQ-013 ISSUE SHALL assert bus_go for exactly one cycle, then go to WAIT.
REQ-014 Latency: X_go sampled at edge t SHALL produce bus_go high in cycle t+2 when the FSM is idle and there is no contention.
REQ-015 bus_done SHALL be honoured only in WAIT; a bus_done in any other state is ignored.
REQ-016 In WAIT, a cycle counter SHALL increment from 0.
- bus_done at cycle w: capture bus_rdData into the granted X_rdata, set err=0, go to RESP.
- Counter reaching TIMEOUT_CYCLES-1 without bus_done: set X_rdata=0, err=1, go to RESP.
- bus_done in the same cycle as expiry: bus_done wins and err=0.
REQ-017 RESP SHALL pulse X_done for one cycle with X_err valid, clear pending_X, then go to IDLE.
- X_done is at cycle w+1 after bus_done at cycle w.
REQ-018 X_rdata SHALL hold its value until that requester's next RESP.
REQ-019 X_err SHALL be 0 whenever X_done is 0.
REQ-020 Only one transaction SHALL be outstanding on the downstream port at any time.
REQ-021 busy SHALL be 1 in ISSUE, WAIT and RESP.

Reset
REQ-022 rst=1 at a clock edge SHALL force the following, including mid-transaction:
- FSM to IDLE; WAIT counter to 0.
- pending_boot and pending_fw to 0; last_grant to 1.
- All outputs to 0: bus_*, X_done, X_rdata, X_err, X_drop, busy, grant_id.
REQ-023 No X_done SHALL be emitted for a transaction aborted by reset.
- A bus_done arriving after reset is ignored under REQ-015.

Verification
REQ-024 Single read: boot_go with addr=0x1000, rw=0 at edge 0 -> bus_go in cycle 2 with bus_addr=0x1000 and bus_RW=0; bus_done with rdData=0xA5..A5 in cycle 5 -> boot_done=1, boot_rdata=0xA5..A5, boot_err=0 in cycle 6.
REQ-025 Contention: boot_go and fw_go on the same edge after reset -> boot is served first, then fw; swap the order and repeat -> the grant alternates each tie.
REQ-026 Timeout: with TIMEOUT_CYCLES=8, fw write with bus_done never asserted -> fw_done=1, fw_err=1, fw_rdata=0 exactly 8 WAIT cycles after entry; a late bus_done is ignored.
REQ-027 Duplicate request: a second boot_go while boot is pending -> boot_drop pulses, and bus_addr shows only the first address.
REQ-028 Reset in WAIT: rst pulsed in a WAIT cycle -> all outputs 0 next cycle, no boot_done, and a later bus_done is ignored.
REQ-029 Back-to-back: boot_go in boot's own RESP cycle -> accepted, and a second bus_go is issued 2 cycles later.
